number_sprite: RTL and testbench

NUMBER_SPRITE -- requirements
Module: number_sprite

---
 rtl/number_sprite.sv | 202 ++++++++++++++++++++
 tb/tb_number_sprite.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/number_sprite.sv
// number_sprite
//   Draws one digit image (out of NUM_IMAGES stored back-to-back in an
//   external image ROM) at a requested screen position, optionally magnified
//   by 2^SCALE_LOG2, with optional colour-key transparency and blinking.
//
//   Position/digit changes are requested with load_req and only take effect
//   at the next frame start (hcount==0 && vcount==0), so a sprite never tears
//   mid-frame.
//
// Ports
//   pixel_clk, reset        : clock, asynchronous active-high reset
//   hcount, vcount          : current raster position
//   x, y, digit, load_req   : placement request (digit must be < NUM_IMAGES)
//   blink_en, trans_en      : blink / transparency enables (levels)
//   load_ack, load_err      : one-cycle pulses: request applied / rejected
//   rom_addr, rom_data      : image ROM (palette index back one cycle later)
//   pal_addr, pal_data      : palette ROM (colour back one cycle later)
//   pixel, pixel_valid      : output colour, 3 cycles after hcount/vcount

module number_sprite #(
    parameter int         WIDTH           = 150,
    parameter int         HEIGHT          = 150,
    parameter int         NUM_IMAGES      = 10,
    parameter int         SCALE_LOG2      = 0,
    parameter int         ADDR_W          = 18,
    parameter logic [7:0] TRANSPARENT_IDX = 8'h00,
    parameter int         BLINK_FRAMES    = 30
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic [10:0]       x,
    input  logic [9:0]        y,
    input  logic [3:0]        digit,
    input  logic              load_req,
    input  logic              blink_en,
    input  logic              trans_en,
    output logic              load_ack,
    output logic              load_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pal_addr,
    input  logic [23:0]       pal_data,
    output logic [23:0]       pixel,
    output logic              pixel_valid
);

    localparam logic [11:0] SPAN_X = 12'(WIDTH << SCALE_LOG2);
    localparam logic [11:0] SPAN_Y = 12'(HEIGHT << SCALE_LOG2);
    localparam int          BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state, next_state;
    logic        capture, apply, reject;
    logic        frame_start, digit_ok;

    logic [10:0] sx, ax;
    logic [9:0]  sy, ay;
    logic [3:0]  sdigit, adigit;

    logic [BW-1:0] blink_cnt;
    logic          phase_on;
    logic          win1, win2;

    logic [11:0] hc, vc, axw, ayw, col, row;
    logic        in_win;
    logic [ADDR_W-1:0] img_addr;

    assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    assign digit_ok    = 32'(digit) < NUM_IMAGES;

    // Load FSM state register
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Load FSM decisions. A legal request arriving on a frame-start cycle
    // while PENDING is captured after the old shadow has been applied, so
    // the FSM stays PENDING for it.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        apply      = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    if (digit_ok) begin
                        capture    = 1'b1;
                        next_state = PENDING;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (load_req) begin
                    if (digit_ok) capture = 1'b1;
                    else          reject  = 1'b1;
                end
                if (frame_start) begin
                    apply = 1'b1;
                    if (!(load_req && digit_ok)) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow/active placement registers and the request handshake pulses
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sx       <= '0;
            sy       <= '0;
            sdigit   <= '0;
            ax       <= '0;
            ay       <= '0;
            adigit   <= '0;
            load_ack <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (apply) begin
                ax     <= sx;
                ay     <= sy;
                adigit <= sdigit;
            end
            if (capture) begin
                sx     <= x;
                sy     <= y;
                sdigit <= digit;
            end
            load_ack <= apply;
            load_err <= reject;
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frame starts; disabled means
    // permanently on with the counter parked at zero.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Window test and ROM address, done in 12 bits so the far edge of a
    // sprite placed near the right/bottom of the raster cannot wrap.
    assign hc  = {1'b0, hcount};
    assign vc  = {2'b0, vcount};
    assign axw = {1'b0, ax};
    assign ayw = {2'b0, ay};

    assign in_win = (hc >= axw) && (hc < axw + SPAN_X) &&
                    (vc >= ayw) && (vc < ayw + SPAN_Y);

    assign col = (hc - axw) >> SCALE_LOG2;
    assign row = (vc - ayw) >> SCALE_LOG2;

    assign img_addr = ADDR_W'(adigit) * ADDR_W'(WIDTH * HEIGHT)
                    + ADDR_W'(row) * ADDR_W'(WIDTH)
                    + ADDR_W'(col);

    // Three-stage pixel pipeline: image ROM address, palette address,
    // final colour. rom_addr is only updated inside the window.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rom_addr    <= '0;
            win1        <= 1'b0;
            pal_addr    <= '0;
            win2        <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            if (in_win) rom_addr <= img_addr;
            win1     <= in_win;
            pal_addr <= rom_data;
            win2     <= win1 && !(trans_en && (rom_data == TRANSPARENT_IDX));
            if (win2 && phase_on) begin
                pixel       <= pal_data;
                pixel_valid <= 1'b1;
            end else begin
                pixel       <= '0;
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_number_sprite.sv
// tb_number_sprite
//   Directed bench for number_sprite (WIDTH=HEIGHT=150, SCALE_LOG2=1,
//   BLINK_FRAMES=2). The image ROM returns addr[7:0]|1 (or zero on demand)
//   and the palette returns {a, ~a, a^8'h3C}, so every output colour can be
//   predicted from the address that produced it.

module tb_number_sprite;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  digit;
    logic        load_req, blink_en, trans_en;
    logic        load_ack, load_err;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        rom_force_zero;

    int vectors     = 0;
    int miscompares = 0;

    number_sprite #(
        .WIDTH(150), .HEIGHT(150), .NUM_IMAGES(10), .SCALE_LOG2(1),
        .ADDR_W(18), .TRANSPARENT_IDX(8'h00), .BLINK_FRAMES(2)
    ) dut (
        .pixel_clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .x(x), .y(y), .digit(digit), .load_req(load_req),
        .blink_en(blink_en), .trans_en(trans_en),
        .load_ack(load_ack), .load_err(load_err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_addr(pal_addr), .pal_data(pal_data),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    // ROM models (combinational, data valid in the cycle after the address)
    assign rom_data = rom_force_zero ? 8'h00 : (rom_addr[7:0] | 8'h01);
    assign pal_data = {pal_addr, ~pal_addr, pal_addr ^ 8'h3C};

    function automatic logic [23:0] colour_of(input logic [17:0] a);
        logic [7:0] p;
        p = a[7:0] | 8'h01;
        return {p, ~p, p ^ 8'h3C};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
    endtask

    // One frame-start cycle, then park the raster away from (0,0)
    task automatic fs_tick();
        applyStimulus(11'd0, 10'd0);
        tick(1);
        applyStimulus(11'd5, 10'd5);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        hcount = 11'd5; vcount = 10'd5;
        x = '0; y = '0; digit = '0;
        load_req = 1'b0; blink_en = 1'b0; trans_en = 1'b0;
        rom_force_zero = 1'b0;
        $display("[TB] starting number_sprite bench");

        tick(2);
        checkOutput("rst_pixel", 32'(pixel), 0);
        checkOutput("rst_valid", 32'(pixel_valid), 0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 0);
        checkOutput("rst_pal_addr", 32'(pal_addr), 0);
        checkOutput("rst_ack", 32'(load_ack), 0);
        checkOutput("rst_err", 32'(load_err), 0);
        reset = 1'b0;

        // Digit 0 at (0,0), x2 magnification: window is 0..299
        applyStimulus(11'd3, 10'd0);
        tick(1);
        checkOutput("h3_rom_addr", 32'(rom_addr), 1);
        tick(2);
        checkOutput("h3_pixel", 32'(pixel), 32'(colour_of(18'd1)));
        checkOutput("h3_valid", 32'(pixel_valid), 1);

        applyStimulus(11'd299, 10'd299);
        tick(1);
        checkOutput("corner_rom_addr", 32'(rom_addr), 22499);
        tick(2);
        checkOutput("corner_pixel", 32'(pixel), 32'(colour_of(18'd22499)));
        checkOutput("corner_valid", 32'(pixel_valid), 1);

        applyStimulus(11'd300, 10'd0);
        tick(1);
        checkOutput("h300_rom_hold", 32'(rom_addr), 22499);
        tick(2);
        checkOutput("h300_valid", 32'(pixel_valid), 0);
        checkOutput("h300_pixel", 32'(pixel), 0);

        applyStimulus(11'd0, 10'd300);
        tick(3);
        checkOutput("v300_rom_hold", 32'(rom_addr), 22499);
        checkOutput("v300_valid", 32'(pixel_valid), 0);

        // Transparency
        applyStimulus(11'd10, 10'd2);
        rom_force_zero = 1'b1;
        trans_en = 1'b1;
        tick(3);
        checkOutput("trans_valid", 32'(pixel_valid), 0);
        checkOutput("trans_pixel", 32'(pixel), 0);
        trans_en = 1'b0;
        tick(3);
        checkOutput("opaque_valid", 32'(pixel_valid), 1);
        checkOutput("opaque_pixel", 32'(pixel), 32'h00FF3C);
        rom_force_zero = 1'b0;
        tick(3);
        checkOutput("pal_addr_155", 32'(pal_addr), 155);
        checkOutput("pixel_155", 32'(pixel), 32'(colour_of(18'd155)));

        // Legal load applied at the next frame start
        x = 11'd100; y = 10'd50; digit = 4'd4; load_req = 1'b1;
        applyStimulus(11'd5, 10'd5);
        tick(1);
        load_req = 1'b0;
        checkOutput("req_no_ack", 32'(load_ack), 0);
        checkOutput("req_no_err", 32'(load_err), 0);
        fs_tick();
        checkOutput("fs_ack", 32'(load_ack), 1);
        applyStimulus(11'd100, 10'd50);
        tick(1);
        checkOutput("ack_single", 32'(load_ack), 0);
        checkOutput("d4_rom_addr", 32'(rom_addr), 90000);
        applyStimulus(11'd102, 10'd51);
        tick(1);
        checkOutput("d4_col1_addr", 32'(rom_addr), 90001);
        tick(2);
        checkOutput("d4_pixel", 32'(pixel), 32'(colour_of(18'd90001)));
        applyStimulus(11'd99, 10'd50);
        tick(1);
        checkOutput("d4_left_hold", 32'(rom_addr), 90001);

        // Illegal digit
        digit = 4'd12; load_req = 1'b1;
        applyStimulus(11'd5, 10'd5);
        tick(1);
        load_req = 1'b0;
        checkOutput("bad_err", 32'(load_err), 1);
        checkOutput("bad_no_ack", 32'(load_ack), 0);
        tick(1);
        checkOutput("bad_err_single", 32'(load_err), 0);
        fs_tick();
        checkOutput("bad_fs_no_ack", 32'(load_ack), 0);
        applyStimulus(11'd100, 10'd50);
        tick(1);
        checkOutput("bad_digit_kept", 32'(rom_addr), 90000);

        // Two legal requests in one frame: the latest wins
        x = 11'd0; y = 10'd0; digit = 4'd1; load_req = 1'b1;
        tick(1);
        digit = 4'd2;
        tick(1);
        load_req = 1'b0;
        fs_tick();
        checkOutput("latest_ack", 32'(load_ack), 1);
        applyStimulus(11'd4, 10'd2);
        tick(1);
        checkOutput("latest_addr", 32'(rom_addr), 45152);

        // Request while PENDING coinciding with frame start
        digit = 4'd3; load_req = 1'b1;
        applyStimulus(11'd5, 10'd5);
        tick(1);
        digit = 4'd5;
        fs_tick();
        load_req = 1'b0;
        checkOutput("pend_fs_ack", 32'(load_ack), 1);
        applyStimulus(11'd1, 10'd0);
        tick(1);
        checkOutput("pend_fs_old", 32'(rom_addr), 67500);
        fs_tick();
        checkOutput("pend_fs_ack2", 32'(load_ack), 1);
        applyStimulus(11'd1, 10'd0);
        tick(1);
        checkOutput("pend_fs_new", 32'(rom_addr), 112500);

        // Request while IDLE coinciding with frame start
        digit = 4'd6; load_req = 1'b1;
        fs_tick();
        load_req = 1'b0;
        checkOutput("idle_fs_no_ack", 32'(load_ack), 0);
        applyStimulus(11'd1, 10'd0);
        tick(1);
        checkOutput("idle_fs_old", 32'(rom_addr), 112500);
        fs_tick();
        checkOutput("idle_fs_ack", 32'(load_ack), 1);
        applyStimulus(11'd1, 10'd0);
        tick(1);
        checkOutput("idle_fs_new", 32'(rom_addr), 135000);

        // Reset while a request is pending
        x = 11'd100; y = 10'd100; digit = 4'd7; load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        reset = 1'b1;
        #2;
        checkOutput("async_rom_addr", 32'(rom_addr), 0);
        checkOutput("async_pal_addr", 32'(pal_addr), 0);
        checkOutput("async_pixel", 32'(pixel), 0);
        checkOutput("async_valid", 32'(pixel_valid), 0);
        tick(2);
        reset = 1'b0;
        fs_tick();
        checkOutput("rst_pend_no_ack", 32'(load_ack), 0);
        applyStimulus(11'd50, 10'd10);
        tick(1);
        checkOutput("rst_pend_addr", 32'(rom_addr), 775);
        tick(2);
        checkOutput("rst_pend_valid", 32'(pixel_valid), 1);
        checkOutput("rst_pend_pixel", 32'(pixel), 32'(colour_of(18'd775)));

        // Blinking, two frames per half-period: on, on, off, off, on, on, off
        blink_en = 1'b1;
        tick(3);
        checkOutput("blink_f0", 32'(pixel_valid), 1);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f1", 32'(pixel_valid), 1);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f2", 32'(pixel_valid), 0);
        checkOutput("blink_f2_pixel", 32'(pixel), 0);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f3", 32'(pixel_valid), 0);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f4", 32'(pixel_valid), 1);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f5", 32'(pixel_valid), 1);
        fs_tick(); applyStimulus(11'd50, 10'd10); tick(3);
        checkOutput("blink_f6", 32'(pixel_valid), 0);
        blink_en = 1'b0;
        tick(3);
        checkOutput("blink_off_forced_on", 32'(pixel_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
